multi_cycle_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS datapath (PC, IR, GRF, EXT, ALU, DM, NPC). It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the existing datapath select and op codes: MUX1, MUX2, MUX3, NPCOp, ALUOp, EXTOp.
- Adds PC and IR write enables and a data-memory ready handshake.
- Instruction set: addu, subu, nop, jr, ori, lw, sw, beq, lui, jal.

---
 rtl/multi_cycle_ctrl_if.sv | 41 ++++
 rtl/multi_cycle_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl_if
// Bundles the signals between the multi-cycle controller and the MIPS datapath.
//   slave  : controller side. It receives instr, zero and dm_ready, and drives
//            the enables, selects, op codes, status pulses and counters.
//   master : datapath/testbench side, with the opposite directions.
// ---------------------------------------------------------------------------
interface multi_cycle_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        dm_ready;
  logic        PCWE;
  logic        IRWE;
  logic        GRFWE;
  logic        DMWE;
  logic        DMRE;
  logic [1:0]  MUX1;
  logic        MUX2;
  logic [1:0]  MUX3;
  logic [1:0]  NPCOp;
  logic [1:0]  ALUOp;
  logic [1:0]  EXTOp;
  logic [2:0]  state;
  logic        instr_done;
  logic        illegal;
  logic        dm_timeout;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  modport slave (
    input  instr, zero, dm_ready,
    output PCWE, IRWE, GRFWE, DMWE, DMRE, MUX1, MUX2, MUX3, NPCOp, ALUOp, EXTOp,
           state, instr_done, illegal, dm_timeout, cycle_cnt, instr_cnt
  );

  modport master (
    output instr, zero, dm_ready,
    input  PCWE, IRWE, GRFWE, DMWE, DMRE, MUX1, MUX2, MUX3, NPCOp, ALUOp, EXTOp,
           state, instr_done, illegal, dm_timeout, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
// Multi-cycle control FSM for the MIPS datapath. It steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB and drives the datapath selects and op codes.
// Supported instructions: addu subu nop jr ori lw sw beq lui jal.
//
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous, active-low reset
//   bus      : multi_cycle_ctrl_if.slave (instr/zero/dm_ready in; enables,
//              selects, op codes, state, status pulses and counters out)
//
// Parameter:
//   DM_WAIT_MAX : number of MEM cycles without dm_ready before the access is
//                 aborted. 0 disables the timeout. Values up to 31 are usable.
//
// Build option:
//   CTRL_PERF_CNT_EN : when defined, adds the free-running cycle counter and the
//                      retired-instruction counter. When undefined, both
//                      outputs are 0.
//
// State | meaning
// ------+---------------------------------------------------------------
// FETCH | IR <- mem[PC], PC <- PC+4
// DECODE| decode; nop/jr/jal/illegal complete here
// EXEC  | ALU operation; beq completes here
// MEM   | DM access, waits for dm_ready or times out
// WB    | register file write-back
// ---------------------------------------------------------------------------
module multi_cycle_ctrl #(
  parameter int DM_WAIT_MAX = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  multi_cycle_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [4:0] W_MAX = DM_WAIT_MAX[4:0];

  state_t     r_state, w_next;
  logic [4:0] r_wait;

  logic [5:0] w_op, w_funct;
  logic       w_addu, w_subu, w_jr, w_nop, w_ori, w_lui, w_lw, w_sw, w_beq, w_jal;
  logic       w_rtype, w_legal, w_wait_hit;

  logic       w_pcwe, w_irwe, w_grfwe, w_dmwe, w_dmre, w_mux2;
  logic       w_done, w_illegal, w_timeout;
  logic [1:0] w_mux1, w_mux3, w_npcop, w_aluop, w_extop;

  // IR is written only in FETCH, so instr stays stable from DECODE through WB
  // and the controller can decode it again in every state.
  assign w_op    = bus.instr[31:26];
  assign w_funct = bus.instr[5:0];
  assign w_nop   = (bus.instr == 32'h0000_0000);
  assign w_addu  = (w_op == 6'h00) && (w_funct == 6'h21);
  assign w_subu  = (w_op == 6'h00) && (w_funct == 6'h23);
  assign w_jr    = (w_op == 6'h00) && (w_funct == 6'h08);
  assign w_ori   = (w_op == 6'h0D);
  assign w_lui   = (w_op == 6'h0F);
  assign w_lw    = (w_op == 6'h23);
  assign w_sw    = (w_op == 6'h2B);
  assign w_beq   = (w_op == 6'h04);
  assign w_jal   = (w_op == 6'h03);
  assign w_rtype = w_addu | w_subu;
  assign w_legal = w_nop | w_rtype | w_jr | w_ori | w_lui | w_lw | w_sw | w_beq | w_jal;

  // r_wait counts MEM cycles that have already passed without dm_ready.
  assign w_wait_hit = (DM_WAIT_MAX != 0) && (r_wait == W_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait <= 5'd0;
    end else if (r_state != S_MEM) begin
      r_wait <= 5'd0;
    end else if (!bus.dm_ready && !w_wait_hit) begin
      r_wait <= r_wait + 5'd1;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_pcwe    = 1'b0;
    w_irwe    = 1'b0;
    w_grfwe   = 1'b0;
    w_dmwe    = 1'b0;
    w_dmre    = 1'b0;
    w_mux1    = 2'b00;
    w_mux2    = 1'b0;
    w_mux3    = 2'b00;
    w_npcop   = 2'b00;
    w_aluop   = 2'b00;
    w_extop   = 2'b00;
    w_done    = 1'b0;
    w_illegal = 1'b0;
    w_timeout = 1'b0;

    // ALU controls are set in EXEC and held through MEM and WB.
    if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
      if (w_subu) begin
        w_aluop = 2'b01;
      end else if (w_ori) begin
        w_aluop = 2'b10;
        w_extop = 2'b01;
        w_mux2  = 1'b1;
      end else if (w_lui) begin
        w_aluop = 2'b10;
        w_extop = 2'b10;
        w_mux2  = 1'b1;
      end else if (w_lw || w_sw) begin
        w_mux2  = 1'b1;
      end else if (w_beq) begin
        w_aluop = 2'b11;
      end
    end

    case (r_state)
      S_FETCH: begin
        w_irwe = 1'b1;
        w_pcwe = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        w_next = S_EXEC;
        if (!w_legal) begin
          w_illegal = 1'b1;
          w_done    = 1'b1;
          w_next    = S_FETCH;
        end else if (w_nop) begin
          w_done = 1'b1;
          w_next = S_FETCH;
        end else if (w_jr) begin
          w_pcwe  = 1'b1;
          w_npcop = 2'b11;
          w_done  = 1'b1;
          w_next  = S_FETCH;
        end else if (w_jal) begin
          // PC already holds PC+4 after FETCH, so this writes the link value.
          w_grfwe = 1'b1;
          w_mux1  = 2'b10;
          w_mux3  = 2'b10;
          w_pcwe  = 1'b1;
          w_npcop = 2'b10;
          w_done  = 1'b1;
          w_next  = S_FETCH;
        end
      end
      S_EXEC: begin
        if (w_beq) begin
          w_npcop = 2'b01;
          w_pcwe  = bus.zero;
          w_done  = 1'b1;
          w_next  = S_FETCH;
        end else if (w_lw || w_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        if (bus.dm_ready) begin
          w_dmre = w_lw;
          w_dmwe = w_sw;
          if (w_lw) begin
            w_next = S_WB;
          end else begin
            w_done = 1'b1;
            w_next = S_FETCH;
          end
        end else if (w_wait_hit) begin
          // Abort: the enables are dropped and no write-back follows.
          w_timeout = 1'b1;
          w_done    = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_dmre = w_lw;
          w_dmwe = w_sw;
        end
      end
      S_WB: begin
        w_grfwe = 1'b1;
        w_done  = 1'b1;
        w_mux1  = w_rtype ? 2'b01 : 2'b00;
        w_mux3  = w_lw ? 2'b01 : 2'b00;
        w_next  = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // reset_n also gates the outputs, so writes stop at once when reset is asserted.
  assign bus.PCWE       = w_pcwe    & reset_n;
  assign bus.IRWE       = w_irwe    & reset_n;
  assign bus.GRFWE      = w_grfwe   & reset_n;
  assign bus.DMWE       = w_dmwe    & reset_n;
  assign bus.DMRE       = w_dmre    & reset_n;
  assign bus.MUX2       = w_mux2    & reset_n;
  assign bus.instr_done = w_done    & reset_n;
  assign bus.illegal    = w_illegal & reset_n;
  assign bus.dm_timeout = w_timeout & reset_n;
  assign bus.MUX1       = reset_n ? w_mux1  : 2'b00;
  assign bus.MUX3       = reset_n ? w_mux3  : 2'b00;
  assign bus.NPCOp      = reset_n ? w_npcop : 2'b00;
  assign bus.ALUOp      = reset_n ? w_aluop : 2'b00;
  assign bus.EXTOp      = reset_n ? w_extop : 2'b00;
  assign bus.state      = r_state;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_cycle_cnt, r_instr_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle_cnt <= 32'd0;
      r_instr_cnt <= 32'd0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_done) begin
        r_instr_cnt <= r_instr_cnt + 32'd1;
      end
    end
  end

  assign bus.cycle_cnt = r_cycle_cnt;
  assign bus.instr_cnt = r_instr_cnt;
`else
  assign bus.cycle_cnt = 32'd0;
  assign bus.instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwe, irwe, grfwe, dmwe, dmre;
    logic [1:0] mux1;
    logic       mux2;
    logic [1:0] mux3, npc, alu, ext;
    logic       done, ill, tmo;
  } obs_t;

  typedef struct packed {
    logic [31:0] ins;
    logic        rdy;
    logic        z;
    obs_t        e;
  } item_t;

  localparam logic [31:0] I_ORI  = 32'h3401_1234;
  localparam logic [31:0] I_ADDU = 32'h0022_1821;
  localparam logic [31:0] I_SUBU = 32'h0022_1823;
  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_LW   = 32'h8C02_0004;
  localparam logic [31:0] I_SW   = 32'hAC02_0008;
  localparam logic [31:0] I_BEQ  = 32'h1021_0002;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_JR   = 32'h03E0_0008;
  localparam logic [31:0] I_LUI  = 32'h3C01_ABCD;
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  multi_cycle_ctrl_if bus ();
  multi_cycle_ctrl #(.DM_WAIT_MAX(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int    checks = 0;
  int    errors = 0;
  item_t q[$];
  item_t it;
  obs_t  got;
  obs_t  e;

  function automatic obs_t sample();
    obs_t s;
    s.st = bus.state; s.pcwe = bus.PCWE; s.irwe = bus.IRWE; s.grfwe = bus.GRFWE;
    s.dmwe = bus.DMWE; s.dmre = bus.DMRE; s.mux1 = bus.MUX1; s.mux2 = bus.MUX2;
    s.mux3 = bus.MUX3; s.npc = bus.NPCOp; s.alu = bus.ALUOp; s.ext = bus.EXTOp;
    s.done = bus.instr_done; s.ill = bus.illegal; s.tmo = bus.dm_timeout;
    return s;
  endfunction

  function automatic obs_t e_st(logic [2:0] s);
    obs_t r = '0;
    r.st = s;
    return r;
  endfunction

  function automatic obs_t e_alu(logic [2:0] s, logic [1:0] a, logic [1:0] x, logic m2);
    obs_t r = e_st(s);
    r.alu = a; r.ext = x; r.mux2 = m2;
    return r;
  endfunction

  task automatic push(logic [31:0] ins, logic rdy, logic z, obs_t ex);
    item_t i;
    i.ins = ins; i.rdy = rdy; i.z = z; i.e = ex;
    q.push_back(i);
  endtask

  task automatic push_fd(logic [31:0] ins);
    obs_t f = e_st(3'd0);
    f.pcwe = 1'b1; f.irwe = 1'b1;
    push(ins, 1'b0, 1'b0, f);
    push(ins, 1'b0, 1'b0, e_st(3'd1));
  endtask

  // Called at posedge+1 with the DUT in FETCH; items are driven after the
  // posedge and compared at the following negedge.
  task automatic test_reset();
    reset_n = 1'b0;
    bus.instr = I_JAL; bus.dm_ready = 1'b0; bus.zero = 1'b0;
    #3;
    got = sample(); checks++;
    if (got !== obs_t'(0)) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", got, obs_t'(0));
    end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_alu_ops();
    int n = 0;
    push_fd(I_ORI);
    push(I_ORI, 0, 0, e_alu(3'd2, 2'b10, 2'b01, 1'b1));
    e = e_alu(3'd4, 2'b10, 2'b01, 1'b1); e.grfwe = 1; e.done = 1;
    push(I_ORI, 0, 0, e);
    push_fd(I_ADDU);
    push(I_ADDU, 0, 0, e_alu(3'd2, 2'b00, 2'b00, 1'b0));
    e = e_alu(3'd4, 2'b00, 2'b00, 1'b0); e.grfwe = 1; e.done = 1; e.mux1 = 2'b01;
    push(I_ADDU, 0, 0, e);
    push_fd(I_SUBU);
    push(I_SUBU, 0, 0, e_alu(3'd2, 2'b01, 2'b00, 1'b0));
    e = e_alu(3'd4, 2'b01, 2'b00, 1'b0); e.grfwe = 1; e.done = 1; e.mux1 = 2'b01;
    push(I_SUBU, 0, 0, e);
    push_fd(I_LUI);
    push(I_LUI, 0, 0, e_alu(3'd2, 2'b10, 2'b10, 1'b1));
    e = e_alu(3'd4, 2'b10, 2'b10, 1'b1); e.grfwe = 1; e.done = 1;
    push(I_LUI, 0, 0, e);
    while (q.size() > 0) begin
      it = q.pop_front();
      bus.instr = it.ins; bus.dm_ready = it.rdy; bus.zero = it.z;
      @(negedge clk);
      got = sample(); checks++;
      if (got !== it.e) begin
        errors++; $display("FAIL alu_ops cyc%0d instr=%h got=%h exp=%h", n, it.ins, got, it.e);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_short();
    int n = 0;
    push_fd(I_NOP);
    q[$].e.done = 1;
    push_fd(I_JAL);
    q[$].e.grfwe = 1; q[$].e.mux1 = 2'b10; q[$].e.mux3 = 2'b10;
    q[$].e.pcwe = 1; q[$].e.npc = 2'b10; q[$].e.done = 1;
    push_fd(I_JR);
    q[$].e.pcwe = 1; q[$].e.npc = 2'b11; q[$].e.done = 1;
    push_fd(I_BAD);
    q[$].e.ill = 1; q[$].e.done = 1;
    push_fd(I_BEQ);
    e = e_alu(3'd2, 2'b11, 2'b00, 1'b0); e.npc = 2'b01; e.pcwe = 1; e.done = 1;
    push(I_BEQ, 0, 1, e);
    push_fd(I_BEQ);
    e.pcwe = 0;
    push(I_BEQ, 0, 0, e);
    while (q.size() > 0) begin
      it = q.pop_front();
      bus.instr = it.ins; bus.dm_ready = it.rdy; bus.zero = it.z;
      @(negedge clk);
      got = sample(); checks++;
      if (got !== it.e) begin
        errors++; $display("FAIL short_ops cyc%0d instr=%h got=%h exp=%h", n, it.ins, got, it.e);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem();
    int n = 0;
    // lw, dm_ready raised on the 4th MEM cycle: 8 cycles in total.
    push_fd(I_LW);
    push(I_LW, 0, 0, e_alu(3'd2, 2'b00, 2'b00, 1'b1));
    for (int k = 0; k < 4; k++) begin
      e = e_alu(3'd3, 2'b00, 2'b00, 1'b1); e.dmre = 1;
      push(I_LW, (k == 3), 0, e);
    end
    e = e_alu(3'd4, 2'b00, 2'b00, 1'b1); e.grfwe = 1; e.done = 1; e.mux3 = 2'b01;
    push(I_LW, 0, 0, e);
    // sw with dm_ready already high on entry: a single MEM cycle.
    push_fd(I_SW);
    push(I_SW, 0, 0, e_alu(3'd2, 2'b00, 2'b00, 1'b1));
    e = e_alu(3'd3, 2'b00, 2'b00, 1'b1); e.dmwe = 1; e.done = 1;
    push(I_SW, 1, 0, e);
    while (q.size() > 0) begin
      it = q.pop_front();
      bus.instr = it.ins; bus.dm_ready = it.rdy; bus.zero = it.z;
      @(negedge clk);
      got = sample(); checks++;
      if (got !== it.e) begin
        errors++; $display("FAIL mem_access cyc%0d instr=%h got=%h exp=%h", n, it.ins, got, it.e);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    push_fd(I_SW);
    push(I_SW, 0, 0, e_alu(3'd2, 2'b00, 2'b00, 1'b1));
    // 16 MEM cycles pass unanswered; the 17th aborts with enables dropped.
    for (int k = 0; k < 16; k++) begin
      e = e_alu(3'd3, 2'b00, 2'b00, 1'b1); e.dmwe = 1;
      push(I_SW, 0, 0, e);
    end
    e = e_alu(3'd3, 2'b00, 2'b00, 1'b1); e.tmo = 1; e.done = 1;
    push(I_SW, 0, 0, e);
    push_fd(I_NOP);
    q[$].e.done = 1;
    while (q.size() > 0) begin
      it = q.pop_front();
      bus.instr = it.ins; bus.dm_ready = it.rdy; bus.zero = it.z;
      @(negedge clk);
      got = sample(); checks++;
      if (got !== it.e) begin
        errors++; $display("FAIL dm_timeout cyc%0d instr=%h got=%h exp=%h", n, it.ins, got, it.e);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_mem();
    int n = 0;
    push_fd(I_SW);
    push(I_SW, 0, 0, e_alu(3'd2, 2'b00, 2'b00, 1'b1));
    for (int k = 0; k < 2; k++) begin
      e = e_alu(3'd3, 2'b00, 2'b00, 1'b1); e.dmwe = 1;
      push(I_SW, 0, 0, e);
    end
    while (q.size() > 0) begin
      it = q.pop_front();
      bus.instr = it.ins; bus.dm_ready = it.rdy; bus.zero = it.z;
      @(negedge clk);
      got = sample(); checks++;
      if (got !== it.e) begin
        errors++; $display("FAIL reset_mid_pre cyc%0d got=%h exp=%h", n, got, it.e);
      end
      n++;
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    got = sample(); checks++;
    if (got !== obs_t'(0)) begin
      errors++; $display("FAIL reset_mid_mem got=%h exp=%h", got, obs_t'(0));
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    push_fd(I_NOP);
    q[$].e.done = 1;
    while (q.size() > 0) begin
      it = q.pop_front();
      bus.instr = it.ins; bus.dm_ready = it.rdy; bus.zero = it.z;
      @(negedge clk);
      got = sample(); checks++;
      if (got !== it.e) begin
        errors++; $display("FAIL reset_mid_restart cyc%0d got=%h exp=%h", n, got, it.e);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_perf();
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] c0, i0;
    c0 = bus.cycle_cnt; i0 = bus.instr_cnt;
    bus.instr = I_NOP;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (bus.cycle_cnt - c0 !== 32'd2) begin
      errors++; $display("FAIL perf_cycle_delta got=%0d exp=2", bus.cycle_cnt - c0);
    end
    checks++;
    if (bus.instr_cnt - i0 !== 32'd1) begin
      errors++; $display("FAIL perf_instr_delta got=%0d exp=1", bus.instr_cnt - i0);
    end
`else
    checks++;
    if (bus.cycle_cnt !== 32'd0) begin
      errors++; $display("FAIL perf_cycle_off got=%h exp=0", bus.cycle_cnt);
    end
    checks++;
    if (bus.instr_cnt !== 32'd0) begin
      errors++; $display("FAIL perf_instr_off got=%h exp=0", bus.instr_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_short();
    test_mem();
    test_timeout();
    test_reset_mid_mem();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
